// File: rtl/priority_resolver_isr.sv
`default_nettype none
// ============================================================================
// Module   : priority_resolver_isr
// Desc     : 8259-style priority resolver and in-service register. Picks the
//            highest-priority unmasked request under a rotating priority
//            order with full nesting, runs the two-pulse INTA handshake,
//            drives the vector byte and executes OCW2 EOI/rotate commands.
// Revision : 1.0 - initial release
// ============================================================================
module priority_resolver_isr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] IRR_priority,
  input  logic [7:0] IMR,
  input  logic       AEOI,
  input  logic [4:0] VECTOR_T,
  input  logic       OCW2_VALID,
  input  logic [2:0] OCW2_CMD,
  input  logic [2:0] OCW2_LEVEL,
  input  logic       INTA_N,
  output logic       INT,
  output logic [7:0] INTA_1,
  output logic       INTA_FREEZE,
  output logic [7:0] ISR,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK1 = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_ACK2 = 2'd3;

  localparam logic [2:0] C_SPURIOUS_LVL = 3'd7;
  localparam logic [2:0] C_LP_RESET     = 3'd7;

  localparam logic [2:0] C_OCW_NS_EOI  = 3'b001;
  localparam logic [2:0] C_OCW_SP_EOI  = 3'b011;
  localparam logic [2:0] C_OCW_ROT_NS  = 3'b101;
  localparam logic [2:0] C_OCW_ROT_SP  = 3'b111;
  localparam logic [2:0] C_OCW_SET_PRI = 3'b110;

  // Reorders a level vector so bit 0 is the current highest-priority level
  // (LP+1) and bit 7 is the lowest (LP).
  function automatic logic [7:0] rot_to_prio(input logic [7:0] vec, input logic [2:0] lp);
    logic [7:0] rot;
    rot = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rot[i] = vec[3'(i) + lp + 3'd1];
    end
    return rot;
  endfunction

  // Index of the lowest set bit (0 when the vector is empty).
  function automatic logic [2:0] first_set(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [1:0] r_state;
  logic [7:0] r_isr;
  logic [2:0] r_lp;
  logic [2:0] r_ackw;
  logic       r_spur;
  logic       r_int;
  logic [7:0] r_inta_1;
  logic       r_inta_n_d;
  logic       r_armed;

  logic [7:0] w_req_rot;
  logic [7:0] w_isr_rot;
  logic       w_isr_any;
  logic [2:0] w_h_rot;
  logic [7:0] w_nest_mask;
  logic [7:0] w_elig_rot;
  logic       w_any_elig;
  logic [2:0] w_win;
  logic [2:0] w_hi;
  logic       w_fall;
  logic       w_ack_start;
  logic [7:0] w_ocw_clr;
  logic       w_lp_load;
  logic [2:0] w_lp_val;
  logic [1:0] w_state_next;
  logic [7:0] w_isr_set;
  logic [7:0] w_aeoi_clr;
  logic [7:0] w_isr_next;

  // Work in priority space: bit 0 = highest priority. Everything below the
  // highest in-service level in that space is allowed to nest.
  assign w_req_rot   = rot_to_prio(IRR_priority & ~IMR, r_lp);
  assign w_isr_rot   = rot_to_prio(r_isr, r_lp);
  assign w_isr_any   = |r_isr;
  assign w_h_rot     = first_set(w_isr_rot);
  assign w_nest_mask = w_isr_any ? ((8'd1 << w_h_rot) - 8'd1) : 8'hFF;
  assign w_elig_rot  = w_req_rot & w_nest_mask;
  assign w_any_elig  = |w_elig_rot;
  assign w_win       = first_set(w_elig_rot) + r_lp + 3'd1;
  assign w_hi        = w_h_rot + r_lp + 3'd1;

  // A falling edge only counts once INTA_N has been seen high since reset,
  // so a strobe already low at reset release cannot start a sequence.
  assign w_fall      = r_armed & r_inta_n_d & ~INTA_N;
  assign w_ack_start = (r_state == S_IDLE) & w_fall;

  // OCW2 command decode: ISR bits to clear and optional new lowest priority
  always_comb begin
    w_ocw_clr = 8'h00;
    w_lp_load = 1'b0;
    w_lp_val  = r_lp;
    if (OCW2_VALID) begin
      case (OCW2_CMD)
        C_OCW_NS_EOI: begin
          if (w_isr_any) w_ocw_clr = 8'd1 << w_hi;
        end
        C_OCW_SP_EOI: begin
          w_ocw_clr = 8'd1 << OCW2_LEVEL;
        end
        C_OCW_ROT_NS: begin
          if (w_isr_any) begin
            w_ocw_clr = 8'd1 << w_hi;
            w_lp_load = 1'b1;
            w_lp_val  = w_hi;
          end
        end
        C_OCW_ROT_SP: begin
          w_ocw_clr = 8'd1 << OCW2_LEVEL;
          w_lp_load = 1'b1;
          w_lp_val  = OCW2_LEVEL;
        end
        C_OCW_SET_PRI: begin
          w_lp_load = 1'b1;
          w_lp_val  = OCW2_LEVEL;
        end
        default: begin
        end
      endcase
    end
  end

  // Acknowledge sequencer next state plus the ISR set/clear it requests
  always_comb begin
    w_state_next = r_state;
    w_isr_set    = 8'h00;
    w_aeoi_clr   = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_ACK1;
          if (w_any_elig) w_isr_set = 8'd1 << w_win;
        end
      end
      S_ACK1: begin
        if (INTA_N) w_state_next = S_GAP;
      end
      S_GAP: begin
        if (w_fall) w_state_next = S_ACK2;
      end
      S_ACK2: begin
        if (INTA_N) begin
          w_state_next = S_IDLE;
          if (AEOI && !r_spur) w_aeoi_clr = 8'd1 << r_ackw;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Set wins over a same-cycle clear of the same bit
  assign w_isr_next = (r_isr & ~(w_ocw_clr | w_aeoi_clr)) | w_isr_set;

  // INTA_N edge detector and post-reset arming
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inta_n_d <= 1'b1;
      r_armed    <= 1'b0;
    end else begin
      r_inta_n_d <= INTA_N;
      if (INTA_N) r_armed <= 1'b1;
    end
  end

  // Sequence state, latched acknowledge level, INT and the INTA_1 pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ackw   <= 3'd0;
      r_spur   <= 1'b0;
      r_int    <= 1'b0;
      r_inta_1 <= 8'h00;
    end else begin
      r_state  <= w_state_next;
      r_int    <= (w_state_next == S_IDLE) & w_any_elig;
      r_inta_1 <= w_isr_set;
      if (w_ack_start) begin
        r_ackw <= w_any_elig ? w_win : C_SPURIOUS_LVL;
        r_spur <= ~w_any_elig;
      end
    end
  end

  // In-service register and rotating lowest-priority pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_isr <= 8'h00;
      r_lp  <= C_LP_RESET;
    end else begin
      r_isr <= w_isr_next;
      if (w_lp_load) r_lp <= w_lp_val;
    end
  end

  assign INT         = r_int;
  assign INTA_1      = r_inta_1;
  assign INTA_FREEZE = (r_state != S_IDLE);
  assign ISR         = r_isr;
  assign DATA_OE     = (r_state == S_ACK2) & ~INTA_N;
  assign DATA_OUT    = DATA_OE ? {VECTOR_T, r_ackw} : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_priority_resolver_isr.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_resolver_isr
// Desc     : Self-checking bench for priority_resolver_isr. A priority-list
//            model of ISR/LP predicts winner, ISR, INTA_1 and vector bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_resolver_isr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] IRR_priority;
  logic [7:0] IMR;
  logic       AEOI;
  logic [4:0] VECTOR_T;
  logic       OCW2_VALID;
  logic [2:0] OCW2_CMD;
  logic [2:0] OCW2_LEVEL;
  logic       INTA_N;
  logic       INT;
  logic [7:0] INTA_1;
  logic       INTA_FREEZE;
  logic [7:0] ISR;
  logic [7:0] DATA_OUT;
  logic       DATA_OE;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] m_isr;
  int         m_lp;
  logic [7:0] last_vec;

  priority_resolver_isr dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IRR_priority (IRR_priority),
    .IMR          (IMR),
    .AEOI         (AEOI),
    .VECTOR_T     (VECTOR_T),
    .OCW2_VALID   (OCW2_VALID),
    .OCW2_CMD     (OCW2_CMD),
    .OCW2_LEVEL   (OCW2_LEVEL),
    .INTA_N       (INTA_N),
    .INT          (INT),
    .INTA_1       (INTA_1),
    .INTA_FREEZE  (INTA_FREEZE),
    .ISR          (ISR),
    .DATA_OUT     (DATA_OUT),
    .DATA_OE      (DATA_OE)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Highest-priority set level of vec under lowest-priority lp, -1 if none
  function automatic int top_of(input logic [7:0] vec, input int lp);
    int l;
    for (int k = 0; k < 8; k++) begin
      l = (lp + 1 + k) % 8;
      if (vec[l]) return l;
    end
    return -1;
  endfunction

  // Walk the priority list from the top; stop at the first in-service level
  function automatic int winner(input logic [7:0] req, input logic [7:0] imr,
                                input logic [7:0] isr, input int lp);
    int l;
    for (int k = 0; k < 8; k++) begin
      l = (lp + 1 + k) % 8;
      if (isr[l]) return -1;
      if (req[l] && !imr[l]) return l;
    end
    return -1;
  endfunction

  task automatic model_ocw(input logic [2:0] cmd, input logic [2:0] lvl, output logic [7:0] clr);
    int h;
    h   = top_of(m_isr, m_lp);
    clr = 8'h00;
    case (cmd)
      3'b001: if (h >= 0) clr[h] = 1'b1;
      3'b011: clr[lvl] = 1'b1;
      3'b101: if (h >= 0) begin clr[h] = 1'b1; m_lp = h; end
      3'b111: begin clr[lvl] = 1'b1; m_lp = int'(lvl); end
      3'b110: m_lp = int'(lvl);
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_isr = 8'h00;
    m_lp  = 7;
  endtask

  task automatic do_ocw(input logic [2:0] cmd, input logic [2:0] lvl);
    logic [7:0] clr;
    OCW2_VALID = 1'b1;
    OCW2_CMD   = cmd;
    OCW2_LEVEL = lvl;
    model_ocw(cmd, lvl, clr);
    m_isr = m_isr & ~clr;
    @(negedge clk);
    OCW2_VALID = 1'b0;
    check_eq("isr_ocw2", ISR, m_isr);
  endtask

  task automatic check_int(input string tag);
    @(negedge clk);
    check_eq(tag, INT, (winner(IRR_priority, IMR, m_isr, m_lp) >= 0) ? 1 : 0);
  endtask

  // Full two-pulse acknowledge starting from IDLE at a falling clock edge
  task automatic ack_seq(input bit ocw_same, input logic [2:0] cmd,
                         input logic [2:0] lvl, input bit change_req);
    int         w;
    logic [7:0] clr;
    logic [7:0] set;
    logic [2:0] ackw;
    bit         spur;
    w   = winner(IRR_priority, IMR, m_isr, m_lp);
    clr = 8'h00;
    if (ocw_same) begin
      OCW2_VALID = 1'b1;
      OCW2_CMD   = cmd;
      OCW2_LEVEL = lvl;
      model_ocw(cmd, lvl, clr);
    end
    spur = (w < 0);
    set  = 8'h00;
    ackw = 3'd7;
    if (!spur) begin
      set[w] = 1'b1;
      ackw   = 3'(w);
    end
    m_isr  = (m_isr & ~clr) | set;
    INTA_N = 1'b0;
    @(negedge clk);
    OCW2_VALID = 1'b0;
    check_eq("inta1_pulse", INTA_1, set);
    check_eq("isr_ack1", ISR, m_isr);
    check_eq("freeze_ack1", INTA_FREEZE, 1);
    check_eq("int_busy", INT, 0);
    INTA_N = 1'b1;
    if (change_req) IRR_priority = 8'($urandom);
    @(negedge clk);
    check_eq("inta1_clear", INTA_1, 0);
    check_eq("oe_gap", DATA_OE, 0);
    INTA_N = 1'b0;
    @(negedge clk);
    last_vec = DATA_OUT;
    check_eq("oe_ack2", DATA_OE, 1);
    check_eq("vector", DATA_OUT, {VECTOR_T, ackw});
    INTA_N = 1'b1;
    if (AEOI && !spur) m_isr[ackw] = 1'b0;
    @(negedge clk);
    check_eq("isr_end", ISR, m_isr);
    check_eq("freeze_end", INTA_FREEZE, 0);
    check_eq("dout_end", DATA_OUT, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    INTA_N       = 1'b1;
    IRR_priority = 8'h00;
    IMR          = 8'h00;
    AEOI         = 1'b0;
    VECTOR_T     = 5'h00;
    OCW2_VALID   = 1'b0;
    OCW2_CMD     = 3'd0;
    OCW2_LEVEL   = 3'd0;
    last_vec     = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_isr", ISR, 0);
    check_eq("rst_int", INT, 0);
    check_eq("rst_inta1", INTA_1, 0);
    check_eq("rst_freeze", INTA_FREEZE, 0);
    check_eq("rst_oe", DATA_OE, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic two-pulse acknowledge, IR2 beats IR3
    IRR_priority = 8'h0C;
    VECTOR_T     = 5'h08;
    check_int("int_basic");
    check_eq("int_basic_hi", INT, 1);
    ack_seq(0, 3'd0, 3'd0, 0);
    check_eq("basic_vec", last_vec, 8'h42);
    check_eq("basic_isr", ISR, 8'h04);

    // Nesting: IR1 pre-empts IR2, IR5 does not; two non-specific EOIs
    IRR_priority = 8'h02;
    check_int("nest_ir1");
    IRR_priority = 8'h20;
    check_int("nest_ir5");
    check_eq("nest_ir5_lo", INT, 0);
    IRR_priority = 8'h02;
    check_int("nest_ir1_again");
    ack_seq(0, 3'd0, 3'd0, 0);
    check_eq("nest_isr06", ISR, 8'h06);
    IRR_priority = 8'h00;
    do_ocw(3'b001, 3'd0);
    check_eq("eoi1_isr", ISR, 8'h04);
    do_ocw(3'b001, 3'd0);
    check_eq("eoi2_isr", ISR, 8'h00);
    do_ocw(3'b101, 3'd0);
    check_eq("eoi_empty", ISR, 8'h00);

    // Specific rotate to L=3, IR4 then outranks IR0
    do_ocw(3'b111, 3'd3);
    IRR_priority = 8'h11;
    check_int("rot_int");
    ack_seq(0, 3'd0, 3'd0, 0);
    check_eq("rot_winner", last_vec[2:0], 3'd4);
    IRR_priority = 8'h00;
    do_ocw(3'b011, 3'd4);
    do_ocw(3'b110, 3'd7);

    // Automatic EOI
    AEOI         = 1'b1;
    IRR_priority = 8'h40;
    check_int("aeoi_int");
    ack_seq(0, 3'd0, 3'd0, 0);
    check_eq("aeoi_isr", ISR, 8'h00);
    AEOI = 1'b0;

    // Request withdrawn before the first edge: spurious
    IRR_priority = 8'h01;
    check_int("spur_int");
    IRR_priority = 8'h00;
    @(negedge clk);
    ack_seq(0, 3'd0, 3'd0, 0);
    check_eq("spur_vec", last_vec[2:0], 3'd7);

    // Reset asserted while in GAP
    IRR_priority = 8'h08;
    check_int("gap_int");
    INTA_N = 1'b0;
    @(negedge clk);
    INTA_N = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("gaprst_freeze", INTA_FREEZE, 0);
    check_eq("gaprst_isr", ISR, 0);
    check_eq("gaprst_int", INT, 0);
    check_eq("gaprst_oe", DATA_OE, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_int("gaprst_int_after");
    ack_seq(0, 3'd0, 3'd0, 0);
    IRR_priority = 8'h00;
    do_ocw(3'b001, 3'd0);

    // Reset released with INTA_N already low: no acknowledge until it rises
    rst_n  = 1'b0;
    INTA_N = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n        = 1'b1;
    IRR_priority = 8'h01;
    repeat (3) @(negedge clk);
    check_eq("lowrel_freeze", INTA_FREEZE, 0);
    check_eq("lowrel_isr", ISR, 0);
    INTA_N = 1'b1;
    check_int("lowrel_int");
    ack_seq(0, 3'd0, 3'd0, 0);

    // Randomized mix of acknowledges, OCW2 commands and idle INT checks
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 4))
        0, 1, 2: begin
          IRR_priority = 8'($urandom);
          IMR          = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
          AEOI         = 1'($urandom_range(0, 1));
          VECTOR_T     = 5'($urandom);
          check_int("rnd_int_pre");
          ack_seq(($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom),
                  1'($urandom_range(0, 1)));
        end
        3: begin
          do_ocw(($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom), 3'($urandom));
        end
        default: begin
          IRR_priority = 8'($urandom);
          IMR          = 8'($urandom) & 8'($urandom);
          check_int("rnd_int_idle");
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/priority_resolver_isr.md
PRIORITY_RESOLVER_ISR -- requirements
Module: priority_resolver_isr

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: IRR_priority  input  8  pending requests from IRR stage, bit n = IRn.
REQ-004 SHALL: IMR  input  8  interrupt mask from control; 1 = masked.
REQ-005 SHALL: AEOI  input  1  automatic end-of-interrupt mode from control.
REQ-006 SHALL: VECTOR_T  input  5  vector base T7..T3 from control.
REQ-007 SHALL: OCW2_VALID  input  1  one-cycle strobe; OCW2_CMD/OCW2_LEVEL valid this cycle.
REQ-008 SHALL: OCW2_CMD  input  3  {R, SL, EOI} command code.
REQ-009 SHALL: OCW2_LEVEL  input  3  level L for specific/rotate/set-priority commands.
REQ-010 SHALL: INTA_N  input  1  interrupt-acknowledge strobe from CPU, active low, synchronous to clk.
REQ-011 SHALL: INT  output  1  interrupt request to CPU.
REQ-012 SHALL: INTA_1  output  8  one-hot, one-cycle pulse clearing the acknowledged bit in IRR.
REQ-013 SHALL: INTA_FREEZE  output  1  holds IRR frozen during acknowledge sequence.
REQ-014 SHALL: ISR  output  8  in-service register.
REQ-015 SHALL: DATA_OUT  output  8  vector byte; DATA_OE  output  1  drive enable.

Function
REQ-016 SHALL: eligible = IRR_priority & ~IMR, restricted to levels of strictly higher priority than the highest-priority set ISR bit (fully nested).
REQ-017 SHALL: priority order rotating; highest = (LP+1) mod 8, descending to LP, where LP is 3-bit lowest-priority register.
REQ-018 SHALL: winner W = highest-priority eligible level, combinational from current ISR, LP, inputs.
REQ-019 SHALL: FSM states IDLE, ACK1, GAP, ACK2; INTA falling edge = INTA_N sampled 1 previous cycle, 0 now.
REQ-020 SHALL: IDLE: INT registered = |eligible, one-cycle latency; INT = 0 in all other states.
REQ-021 SHALL: IDLE + falling edge -> ACK1: latch W into ACKW, set ISR[W], INTA_1 = onehot(W) that cycle only, INTA_FREEZE = 1.
REQ-022 SHALL: spurious case (no eligible at first edge): ACKW = 7, ISR unchanged, INTA_1 = 0, sequence continues.
REQ-023 SHALL: ACK1 -> GAP on INTA_N = 1; GAP -> ACK2 on falling edge.
REQ-024 SHALL: ACK2: DATA_OUT = {VECTOR_T, ACKW}, DATA_OE = 1 while INTA_N = 0; DATA_OE = 0 and DATA_OUT = 0 otherwise.
REQ-025 SHALL: ACK2 -> IDLE on INTA_N = 1; that cycle INTA_FREEZE -> 0 and, if AEOI = 1 and not spurious, ISR[ACKW] cleared.
REQ-026 SHALL: OCW2 codes: 001 non-specific EOI clears highest-priority set ISR bit; 011 clears ISR[L]; 101 clears highest set bit H and LP = H; 111 clears ISR[L] and LP = L; 110 LP = L; all other codes no-op.
REQ-027 SHALL: non-specific EOI (001/101) with ISR = 0 changes nothing, including LP.
REQ-028 SHALL: same-cycle OCW2 and first INTA edge: W computed from pre-update ISR/LP; ISR_next = (ISR & ~clr) | set.
REQ-029 SHALL: requests arriving during ACK1..ACK2 do not alter ACKW or DATA_OUT.

Reset
REQ-030 SHALL: rst_n = 0 asynchronously forces state IDLE, ISR = 0, LP = 7 (IR0 highest), ACKW = 0, INT = 0, INTA_1 = 0, INTA_FREEZE = 0, DATA_OUT = 0, DATA_OE = 0, edge-detector register = 1.
REQ-031 SHALL: reset asserted mid-sequence aborts it; after release an INTA_N already low produces no falling edge until it returns high.

Verification
REQ-032 SHALL: IRR_priority = 0x0C, IMR = 0, VECTOR_T = 0x08, two INTA pulses -> INT = 1, INTA_1 = 0x04, ISR = 0x04, DATA_OUT = 0x42.
REQ-033 SHALL: ISR = 0x04, request IR1 then IR5 -> IR1 raises INT, IR5 does not; non-specific EOI twice -> ISR 0x06 -> 0x04 -> 0x00.
REQ-034 SHALL: OCW2 111 L = 3, then requests 0x11 -> winner IR4 (highest after rotation), DATA_OUT low bits = 100.
REQ-035 SHALL: AEOI = 1, request IR6 acknowledged -> ISR = 0x40 during sequence, 0x00 after second INTA_N rising edge.
REQ-036 SHALL: request withdrawn before first INTA edge -> spurious: INTA_1 = 0, ISR = 0, vector low bits = 111.
REQ-037 SHALL: rst_n pulsed in GAP -> all outputs to REQ-030 values immediately; next clean two-pulse sequence completes normally.
